// File: rtl/cla_arbiter_if.sv
// cla_arbiter_if: request, shared-adder and result channels of the
// cla_arbiter. The requester side uses the master modport, the arbiter
// uses slave, and the shared adder uses the adder modport.
interface cla_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_cin;

  logic [15:0]           add_a;
  logic [15:0]           add_b;
  logic                  add_cin;
  logic [15:0]           add_sum;

  logic                  res_valid;
  logic                  res_ready;
  logic [ID_W-1:0]       res_id;
  logic [15:0]           res_sum;
  logic                  res_ovf;

  modport master (
    output req_valid, req_a, req_b, req_cin, res_ready,
    input  req_ready, res_valid, res_id, res_sum, res_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, res_ready, add_sum,
    output req_ready, res_valid, res_id, res_sum, res_ovf,
           add_a, add_b, add_cin
  );

  modport adder (
    input  add_a, add_b, add_cin,
    output add_sum
  );
endinterface

// File: rtl/cla_arbiter.sv
// cla_arbiter: round-robin sequencer sharing one external 16-bit adder
// among NUM_REQ requesters. One request is in flight at a time:
// IDLE (arbitrate/accept) -> CALC (adder evaluates) -> DONE (hold result).
// Optional feature macro: CLA_ARB_SAT_EN (saturate res_sum on signed overflow).
module cla_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic         clk,
  input  logic         rst,
  cla_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [15:0]     add_a_q, add_a_d;
  logic [15:0]     add_b_q, add_b_d;
  logic            add_cin_q, add_cin_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic [15:0]     res_sum_q, res_sum_d;
  logic            res_ovf_q, res_ovf_d;

  logic [15:0]        op_a [NUM_REQ];
  logic [15:0]        op_b [NUM_REQ];
  logic               grant_found;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    idx;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               ovf_c;
  logic [15:0]        sum_sel;

  // Unpack the flat operand buses into per-requester words.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_a[gi] = bus.req_a[16*gi +: 16];
      assign op_b[gi] = bus.req_b[16*gi +: 16];
    end
  endgenerate

  // Round-robin search: first pending requester upward from ptr+1, wrapping.
  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    idx         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        winner      = idx;
      end
    end
  end

  // Overflow of the operands held in the adder; with saturation the result
  // clamps toward the sign of the operands (a and b share a sign on overflow).
  always_comb begin
    ovf_c = (add_a_q[15] == add_b_q[15]) && (bus.add_sum[15] != add_a_q[15]);
`ifdef CLA_ARB_SAT_EN
    sum_sel = ovf_c ? (add_a_q[15] ? 16'h8000 : 16'h7FFF) : bus.add_sum;
`else
    sum_sel = bus.add_sum;
`endif
  end

  // Next-state and datapath loads for the three-phase sequence.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    res_id_d    = res_id_q;
    res_sum_d   = res_sum_q;
    res_ovf_d   = res_ovf_q;
    req_ready_c = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_c[winner] = 1'b1;
          add_a_d   = op_a[winner];
          add_b_d   = op_b[winner];
          add_cin_d = bus.req_cin[winner];
          res_id_d  = winner;
          ptr_d     = winner;
          state_d   = CALC;
        end
      end
      CALC: begin
        res_sum_d = sum_sel;
        res_ovf_d = ovf_c;
        state_d   = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset overrides any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= ID_W'(NUM_REQ - 1);
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      res_id_q  <= '0;
      res_sum_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
      res_id_q  <= res_id_d;
      res_sum_q <= res_sum_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  // Accept strobe is masked during reset so no requester sees a handshake
  // that the reset edge will discard.
  assign bus.req_ready = rst ? '0 : req_ready_c;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_id    = res_id_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_cla_arbiter.sv
// tb_cla_arbiter: directed scoreboard bench for cla_arbiter. Expected grant
// IDs and results are queued as stimulus is issued; two monitors pop and
// compare on grants and on result handshakes.
module tb_cla_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

`ifdef CLA_ARB_SAT_EN
  localparam logic [15:0] OVF_POS = 16'h7FFF;
  localparam logic [15:0] OVF_NEG = 16'h8000;
`else
  localparam logic [15:0] OVF_POS = 16'h8000;
  localparam logic [15:0] OVF_NEG = 16'h7FFF;
`endif
  // Expected sums for positive-operand overflows (7FFF+1, 4000+4000) and
  // negative ones (8000+FFFF, 8000+8000).
`ifdef CLA_ARB_SAT_EN
  localparam logic [15:0] OVF_NEG2 = 16'h8000;
`else
  localparam logic [15:0] OVF_NEG2 = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  cla_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  cla_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared adder stand-in.
  assign bus.add_sum = bus.add_a + bus.add_b + {15'd0, bus.add_cin};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          grant_q [$];
  logic [18:0] res_q   [$];

  int last_grant_cyc = -100;
  int hs_cyc         = -100;
  bit gap_check      = 1'b0;
  bit gap_armed      = 1'b0;
  bit chk_after_hs   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [ID_W-1:0] id, input logic [15:0] sum, input logic ovf);
    grant_q.push_back(int'(id));
    res_q.push_back({id, ovf, sum});
  endtask

  task automatic drive(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
    bus.req_a[16*i +: 16]      = a;
    bus.req_b[16*i +: 16]      = b;
    bus.req_cin[i[ID_W-1:0]]   = c;
    bus.req_valid[i[ID_W-1:0]] = 1'b1;
  endtask

  // Wait for requester i to be accepted, then drop its valid after the edge.
  task automatic wait_grant(input int i);
    bit got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (bus.req_valid[i[ID_W-1:0]] && bus.req_ready[i[ID_W-1:0]]) begin
        got = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid[i[ID_W-1:0]] = 1'b0;
      end
    end
    check("grant_wait", 32'(got), 32'd1);
  endtask

  // Wait for any accept; returns the granted index (or -1) just after the edge.
  task automatic wait_any_grant(output int g);
    g = -1;
    for (int t = 0; t < 60 && g < 0; t++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i[ID_W-1:0]] && bus.req_ready[i[ID_W-1:0]]) g = i;
      end
    end
    if (g >= 0) begin
      @(posedge clk);
      #1;
    end
    check("any_grant_wait", 32'(g >= 0), 32'd1);
  endtask

  // Grant monitor: identity of each accept and accept spacing.
  initial begin
    int g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (bus.req_valid[i[ID_W-1:0]] && bus.req_ready[i[ID_W-1:0]]) begin
            if (grant_q.size() == 0) begin
              check("unexpected_grant", 32'(i), 32'hFFFF);
            end else begin
              g = grant_q.pop_front();
              check("grant_id", 32'(i), 32'(g));
            end
            if (gap_check && gap_armed) check("grant_gap", 32'(cyc - last_grant_cyc), 32'd3);
            gap_armed = gap_check;
            if (chk_after_hs) begin
              check("accept_after_hs", 32'(cyc), 32'(hs_cyc + 1));
              chk_after_hs = 1'b0;
            end
            last_grant_cyc = cyc;
            $display("grant: id=%0d cycle=%0d", i, cyc);
          end
        end
      end
    end
  end

  // Result monitor: latency from accept and contents on each handshake.
  initial begin
    bit          prev_valid = 1'b0;
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (bus.res_valid && !prev_valid) check("latency", 32'(cyc - last_grant_cyc), 32'd2);
      if (bus.res_valid && bus.res_ready) begin
        hs_cyc = cyc;
        if (res_q.size() == 0) begin
          check("unexpected_result", {15'd0, bus.res_ovf, bus.res_sum}, 32'hDEAD_BEEF);
        end else begin
          e = res_q.pop_front();
          check("res_id",  32'(bus.res_id),  32'(e[18:17]));
          check("res_sum", 32'(bus.res_sum), 32'(e[15:0]));
          check("res_ovf", 32'(bus.res_ovf), 32'(e[16]));
        end
        $display("result: id=%0d sum=0x%04h ovf=%0d cycle=%0d",
                 bus.res_id, bus.res_sum, bus.res_ovf, cyc);
      end
      prev_valid = bus.res_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  g;
    bit  reloaded;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.res_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_id",    32'(bus.res_id),    32'd0);
    check("rst_res_sum",   32'(bus.res_sum),   32'd0);
    check("rst_res_ovf",   32'(bus.res_ovf),   32'd0);
    check("rst_add_a",     32'(bus.add_a),     32'd0);
    check("rst_add_b",     32'(bus.add_b),     32'd0);
    check("rst_add_cin",   32'(bus.add_cin),   32'd0);
    @(posedge clk); #1;

    // Single request and overflow vectors
    push_exp(2'd0, 16'h0008, 1'b0); drive(0, 16'h0003, 16'h0004, 1'b1); wait_grant(0);
    push_exp(2'd1, OVF_POS,  1'b1); drive(1, 16'h7FFF, 16'h0001, 1'b0); wait_grant(1);
    push_exp(2'd2, OVF_NEG,  1'b1); drive(2, 16'h8000, 16'hFFFF, 1'b0); wait_grant(2);
    push_exp(2'd3, 16'hFFFF, 1'b0); drive(3, 16'hFFFF, 16'hFFFF, 1'b1); wait_grant(3);
    repeat (4) @(posedge clk); #1;

    // Round robin with all four pending, res_ready tied high
    gap_check = 1'b1;
    push_exp(2'd0, 16'h1234, 1'b0);
    push_exp(2'd1, 16'h0101, 1'b0);
    push_exp(2'd2, OVF_POS,  1'b1);
    push_exp(2'd3, 16'h0000, 1'b0);
    push_exp(2'd0, 16'h0002, 1'b0);
    drive(0, 16'h1000, 16'h0234, 1'b0);
    drive(1, 16'h00FF, 16'h0001, 1'b1);
    drive(2, 16'h4000, 16'h4000, 1'b0);
    drive(3, 16'hFFF0, 16'h0010, 1'b0);
    reloaded = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_any_grant(g);
      if (g >= 0) begin
        if (g == 0 && !reloaded) begin
          reloaded = 1'b1;
          drive(0, 16'h0001, 16'h0001, 1'b0);
        end else begin
          bus.req_valid[g[ID_W-1:0]] = 1'b0;
        end
      end
    end
    repeat (4) @(posedge clk); #1;
    gap_check = 1'b0;

    // Backpressure: result held while req1 waits
    bus.res_ready = 1'b0;
    push_exp(2'd2, 16'h000B, 1'b0); drive(2, 16'h0005, 16'h0006, 1'b0); wait_grant(2);
    push_exp(2'd1, 16'h0300, 1'b0); drive(1, 16'h0100, 16'h0200, 1'b0);
    @(negedge clk);
    check("bp_calc_ready", 32'(bus.req_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.res_valid), 32'd1);
      check("bp_sum",   32'(bus.res_sum),   32'h000B);
      check("bp_id",    32'(bus.res_id),    32'd2);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk_after_hs  = 1'b1;
    bus.res_ready = 1'b1;
    wait_grant(1);
    repeat (4) @(posedge clk); #1;

    // Reset pulse while in CALC
    grant_q.push_back(2);
    drive(2, 16'h1111, 16'h2222, 1'b0); wait_grant(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstcalc_add_a",   32'(bus.add_a),   32'd0);
    check("rstcalc_res_sum", 32'(bus.res_sum), 32'd0);
    check("rstcalc_valid",   32'(bus.res_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstcalc_valid", 32'(bus.res_valid), 32'd0);
    end
    @(posedge clk); #1;
    push_exp(2'd0, 16'h0030, 1'b0);
    push_exp(2'd3, OVF_NEG2, 1'b1);
    drive(0, 16'h0010, 16'h0020, 1'b0);
    drive(3, 16'h8000, 16'h8000, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_any_grant(g);
      if (g >= 0) bus.req_valid[g[ID_W-1:0]] = 1'b0;
    end
    repeat (5) @(posedge clk); #1;

    check("grant_q_empty", 32'(grant_q.size()), 32'd0);
    check("res_q_empty",   32'(res_q.size()),   32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_arbiter.md
# cla_arbiter

Round-robin arbiter and sequencer that shares one 16-bit carry-lookahead adder among `NUM_REQ` requesters in the autoencoder datapath, such as neuron accumulators and bias adders. It accepts one request at a time over a valid/ready handshake and registers the operands into the shared adder. It captures the sum and returns it with the requester ID over a valid/ready result channel. Signed-overflow detection is always present; saturation is compile-time optional.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default 2: result ID width, equal to `$clog2(NUM_REQ)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_ready`  out  NUM_REQ  one-hot accept strobe; the request is taken when both `req_valid[i]` and `req_ready[i]` are high.
- `req_a`  in  16*NUM_REQ  operand A; requester i uses bits [16i+15:16i].
- `req_b`  in  16*NUM_REQ  operand B, packed the same way.
- `req_cin`  in  NUM_REQ  carry-in per requester.
- `add_a`, `add_b`  out  16  registered operands driven to the shared adder.
- `add_cin`  out  1  registered carry-in driven to the adder.
- `add_sum`  in  16  combinational sum returned by the adder.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_id`  out  ID_W  index of the requester that owns the result.
- `res_sum`  out  16  registered result.
- `res_ovf`  out  1  signed overflow occurred on this result.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If any `req_valid` is high, the winner is the first set bit searching upward from `ptr+1` modulo NUM_REQ.
  - `req_ready[winner]` is asserted combinationally in that cycle.
  - On the clock edge the winner's operands go to `add_a`/`add_b`/`add_cin`, its index goes to `res_id`, `ptr` becomes the winner, and the FSM moves to CALC.
  - With no request pending, the FSM stays in IDLE and `req_ready` is 0.
- CALC:
  - The adder evaluates the registered operands.
  - On the clock edge, `add_sum` is captured into `res_sum` and the overflow is captured into `res_ovf`; the FSM moves to DONE.
- DONE:
  - `res_valid` is 1.
  - `res_sum`, `res_id` and `res_ovf` are held stable until `res_ready` is 1.
  - On that edge the FSM moves to IDLE.
- `req_ready` is 0 in both CALC and DONE.
- Overflow rule: `ovf = (a[15]==b[15]) && (sum[15]!=a[15])`. The rule is valid with carry-in because carry-in adds at most 1.
- Sums wrap modulo 2^16 unless saturation is enabled.
- `req_valid` does not need to be held after acceptance. Requests that are not granted must stay asserted with stable operands.

## Timing
- Reset values:
  - FSM in IDLE, `ptr = NUM_REQ-1`, so requester 0 wins first.
  - `req_ready = 0`, `res_valid = 0`.
  - `res_id = 0`, `res_sum = 0`, `res_ovf = 0`.
  - `add_a = 0`, `add_b = 0`, `add_cin = 0`.
- Latency:
  - Accept at cycle N.
  - CALC at cycle N+1.
  - `res_valid` high from cycle N+2.
- Throughput is one result per 3 cycles when `res_ready` is tied high.
- A new accept is possible in the cycle after the `res_ready` handshake.
- Fairness: each requester that holds `req_valid` is served within NUM_REQ grants.
- Reset asserted in any state wins over every other event. Any in-flight transaction is dropped, no `res_valid` is produced for it, and all registers take their reset values on that edge.
- `res_ready` high while `res_valid` is low has no effect.

## Configuration
- `CLA_ARB_SAT_EN` defined:
  - on overflow, `res_sum` is clamped to 16'h7FFF when `a[15]` is 0, or to 16'h8000 when `a[15]` is 1;
  - `res_ovf` is still 1.
- Not defined: `res_sum` is the raw wrapped `add_sum` and `res_ovf` is flag-only.

## Test plan
- Single request:
  - Stimulus: req0 with a=0x0003, b=0x0004, cin=1.
  - Response: `req_ready[0]` at N; `res_valid` at N+2 with `res_sum`=0x0008, `res_id`=0, `res_ovf`=0.
- Round-robin, NUM_REQ=4:
  - Stimulus: all four requesters hold `req_valid`; `res_ready` tied 1.
  - Response: grant order 0,1,2,3,0 with accepts every 3 cycles.
- Overflow:
  - Stimulus: a=0x7FFF, b=0x0001.
  - Response: `res_ovf`=1. `res_sum`=0x8000 without the macro, 0x7FFF with `CLA_ARB_SAT_EN`.
  - Stimulus: a=0x8000, b=0xFFFF.
  - Response: `res_ovf`=1. `res_sum`=0x7FFF without the macro, 0x8000 with it.
- Backpressure:
  - Stimulus: `res_ready` held 0 for 5 cycles while req1 stays valid.
  - Response: `res_sum`/`res_id` stay stable; `req_ready` stays 0; req1 is accepted the cycle after `res_ready` rises.
- Reset in CALC:
  - Stimulus: `rst` pulsed for 1 cycle while in CALC.
  - Response: no `res_valid` for that request; `ptr` is reset, so requester 0 wins the next arbitration.
